// File: rtl/fft_peak_finder.sv
// Bin-serial FFT peak finder: squares each incoming complex bin and tracks the
// strongest bin in the lower half-spectrum (excluding DC), reported once per frame.
module fft_peak_finder #(
    parameter int unsigned N_BINS  = 32,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MIN_MAG = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [2*DATA_W-1:0]         in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    output logic [$clog2(N_BINS)-1:0]   peak_bin,
    output logic [2*DATA_W:0]           peak_mag,
    output logic                        peak_found,
    output logic                        frame_err,
    output logic                        result_valid,
    input  logic                        result_ack
);

    localparam int unsigned BW    = $clog2(N_BINS);
    localparam int unsigned SQ_W  = 2*DATA_W;
    localparam int unsigned MAG_W = 2*DATA_W+1;
    localparam logic [BW-1:0]    LAST_BIN  = BW'(N_BINS-1);
    localparam logic [BW-1:0]    HALF_BIN  = BW'(N_BINS/2);
    localparam logic [MAG_W-1:0] MIN_MAG_L = MAG_W'(MIN_MAG);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;
    state_t state, state_nx;

    logic                     xfer;
    logic [BW-1:0]            bin_cnt;
    logic                     err;

    logic                     cap_valid;
    logic [BW-1:0]            cap_bin;
    logic signed [DATA_W-1:0] cap_re, cap_im;

    logic                     s1_valid;
    logic [BW-1:0]            s1_bin;
    logic [SQ_W-1:0]          s1_re2, s1_im2;

    logic signed [SQ_W-1:0]   re_sq, im_sq;
    logic [MAG_W-1:0]         mag;
    logic                     in_window;

    logic [MAG_W-1:0]         best_mag;
    logic [BW-1:0]            best_bin;

    assign xfer = in_valid & in_ready;

    // Squares of two's complement values are non-negative, so the signed product
    // fits SQ_W bits and is reinterpreted as unsigned (including -2^(W-1) squared).
    assign re_sq     = cap_re * cap_re;
    assign im_sq     = cap_im * cap_im;
    assign mag       = {1'b0, s1_re2} + {1'b0, s1_im2};
    assign in_window = (s1_bin != '0) && (s1_bin < HALF_BIN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        in_ready     = 1'b0;
        result_valid = 1'b0;
        unique case (state)
            IDLE:  state_nx = ACCUM;
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_nx = DRAIN;
            end
            DRAIN: if (!cap_valid && !s1_valid) state_nx = HOLD;
            HOLD: begin
                result_valid = 1'b1;
                if (result_ack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin_cnt    <= '0;
            err        <= 1'b0;
            cap_valid  <= 1'b0;
            cap_bin    <= '0;
            cap_re     <= '0;
            cap_im     <= '0;
            s1_valid   <= 1'b0;
            s1_bin     <= '0;
            s1_re2     <= '0;
            s1_im2     <= '0;
            best_mag   <= '0;
            best_bin   <= '0;
            peak_bin   <= '0;
            peak_mag   <= '0;
            peak_found <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            cap_valid <= xfer;
            if (xfer) begin
                cap_re  <= in_data[2*DATA_W-1:DATA_W];
                cap_im  <= in_data[DATA_W-1:0];
                cap_bin <= bin_cnt;
                bin_cnt <= bin_cnt + BW'(1);
                if (in_last != (bin_cnt == LAST_BIN)) err <= 1'b1;
            end

            s1_valid <= cap_valid;
            s1_bin   <= cap_bin;
            s1_re2   <= re_sq;
            s1_im2   <= im_sq;

            if (state == IDLE) begin
                bin_cnt  <= '0;
                err      <= 1'b0;
                best_mag <= '0;
                best_bin <= '0;
            end else if (s1_valid && in_window && (mag > best_mag)) begin
                best_mag <= mag;
                best_bin <= s1_bin;
            end

            if (state == DRAIN && state_nx == HOLD) begin
                peak_bin   <= best_bin;
                peak_mag   <= best_mag;
                peak_found <= (best_mag > MIN_MAG_L);
                frame_err  <= err;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_finder.sv
// Randomised self-checking bench for fft_peak_finder against a frame-level
// reference model (strongest bin of 1..N/2-1, strict compare, length-based error).
module tb_fft_peak_finder;

    localparam int N      = 32;
    localparam int W      = 16;
    localparam int MINMAG = 0;
    localparam int BW     = $clog2(N);
    localparam int MAX_LEN = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [2*W-1:0]    in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [BW-1:0]     peak_bin;
    logic [2*W:0]      peak_mag;
    logic              peak_found;
    logic              frame_err;
    logic              result_valid;
    logic              result_ack;

    int n_tests = 0;
    int n_fail  = 0;

    int      fre [MAX_LEN];
    int      fim [MAX_LEN];
    longint  exp_mag;
    int      exp_bin;
    bit      exp_err;
    bit      exp_found;

    fft_peak_finder #(.N_BINS(N), .DATA_W(W), .MIN_MAG(MINMAG)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_last      (in_last),
        .peak_bin     (peak_bin),
        .peak_mag     (peak_mag),
        .peak_found   (peak_found),
        .frame_err    (frame_err),
        .result_valid (result_valid),
        .result_ack   (result_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model(input int len);
        longint mag;
        int idx;
        exp_mag = 0;
        exp_bin = 0;
        for (int k = 0; k < len; k++) begin
            idx = k % N;
            if (idx >= 1 && idx < N/2) begin
                mag = longint'(fre[k])*fre[k] + longint'(fim[k])*fim[k];
                if (mag > exp_mag) begin
                    exp_mag = mag;
                    exp_bin = idx;
                end
            end
        end
        exp_err   = (len != N);
        exp_found = (exp_mag > MINMAG);
    endfunction

    function automatic void clear_frame();
        for (int k = 0; k < MAX_LEN; k++) begin
            fre[k] = 0;
            fim[k] = 0;
        end
    endfunction

    function automatic int rnd_val();
        int r;
        int v;
        r = $urandom_range(99);
        if (r < 25) begin
            case ($urandom_range(3))
                0: v = 0;
                1: v = 100;
                2: v = -100;
                default: v = 200;
            endcase
        end else if (r < 35) begin
            v = -32768;
        end else begin
            v = $urandom_range(65535) - 32768;
        end
        return v;
    endfunction

    task automatic run_frame(input int len, input int gap_pct, input int ack_dly);
        int k;
        int budget;
        int lat;
        model(len);
        k = 0;
        budget = 4000;
        while (k < len && budget > 0) begin
            @(negedge clk);
            budget--;
            in_valid   = ($urandom_range(99) >= gap_pct);
            in_data    = {16'(fre[k]), 16'(fim[k])};
            in_last    = (k == len-1);
            result_ack = (gap_pct > 0) ? 1'($urandom_range(1)) : 1'b0;
            if (in_valid && in_ready) k++;
        end
        check("xfer_count", 64'(k), 64'(len));
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        result_ack = 1'b0;
        lat = 1;
        while (!result_valid && lat < 20) begin
            check("ready_drain", 64'(in_ready), 64'(0));
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat-1), 64'(3));
        check("peak_bin", 64'(peak_bin), 64'(exp_bin));
        check("peak_mag", 64'(peak_mag), 64'(exp_mag));
        check("peak_found", 64'(peak_found), 64'(exp_found));
        check("frame_err", 64'(frame_err), 64'(exp_err));
        for (int i = 0; i < ack_dly; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 64'(result_valid), 64'(1));
            check("ready_hold", 64'(in_ready), 64'(0));
            check("hold_mag", 64'(peak_mag), 64'(exp_mag));
        end
        result_ack = 1'b1;
        @(posedge clk);
        #1;
        result_ack = 1'b0;
        check("valid_fall", 64'(result_valid), 64'(0));
    endtask

    initial begin
        int len;
        int k;
        reset      = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        result_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(in_ready), 64'(0));
        check("rst_valid", 64'(result_valid), 64'(0));
        check("rst_mag", 64'(peak_mag), 64'(0));
        check("rst_bin", 64'(peak_bin), 64'(0));
        check("rst_found", 64'(peak_found), 64'(0));
        check("rst_err", 64'(frame_err), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        clear_frame();
        fre[5] = 1000;
        run_frame(N, 0, 2);

        clear_frame();
        fre[3] = 300;    fim[3] = 400;
        fre[9] = 300;    fim[9] = 400;
        fre[0] = 30000;
        fre[20] = 32767; fim[20] = 32767;
        run_frame(N, 0, 1);

        clear_frame();
        fre[7] = -32768; fim[7] = -32768;
        run_frame(N, 0, 0);
        check("extreme_mag", 64'(peak_mag), 64'h8000_0000);

        clear_frame();
        fre[4] = 50;
        run_frame(20, 0, 0);
        run_frame(33, 0, 0);

        for (int f = 0; f < 100; f++) begin
            case ($urandom_range(9))
                0: len = 20;
                1: len = 33;
                2: len = $urandom_range(40, 1);
                default: len = N;
            endcase
            for (int i = 0; i < MAX_LEN; i++) begin
                fre[i] = rnd_val();
                fim[i] = rnd_val();
            end
            run_frame(len, $urandom_range(50), $urandom_range(5));
        end

        clear_frame();
        k = 0;
        while (k < 12) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_last  = 1'b0;
            in_data  = {16'(32000), 16'(-32000)};
            if (in_ready) k++;
        end
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_ready", 64'(in_ready), 64'(0));
        check("midrst_valid", 64'(result_valid), 64'(0));
        check("midrst_mag", 64'(peak_mag), 64'(0));
        check("midrst_bin", 64'(peak_bin), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        run_frame(N, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
